// File: rtl/mem_stream_loader_if.sv
// mem_stream_loader_if
// Bundles the signals between the boot/debug byte source, the loader and
// the synchronous memory write port, so they can be passed as a single port.
//   Control    : start, load_len (words to load)
//   Byte stream: byte_valid, byte_data (in), byte_ready (out)
//   Memory port: mem_wEn, mem_addr, mem_dataIn (out)
//   Status     : busy, done, words_written (out)
// The slave modport is the loader's view. The master modport is the view of
// whatever drives it, such as a boot controller or a testbench.
interface mem_stream_loader_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
);
  logic                     start;
  logic [ADDRESS_WIDTH:0]   load_len;
  logic                     byte_valid;
  logic [7:0]               byte_data;
  logic                     byte_ready;
  logic                     mem_wEn;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_dataIn;
  logic                     busy;
  logic                     done;
  logic [ADDRESS_WIDTH:0]   words_written;

  modport slave (
    input  start, load_len, byte_valid, byte_data,
    output byte_ready, mem_wEn, mem_addr, mem_dataIn, busy, done, words_written
  );

  modport master (
    output start, load_len, byte_valid, byte_data,
    input  byte_ready, mem_wEn, mem_addr, mem_dataIn, busy, done, words_written
  );
endinterface

// File: rtl/mem_stream_loader.sv
// mem_stream_loader
// Packs an incoming byte stream, MSB first, into DATA_WIDTH-bit words. The
// words are written to consecutive memory addresses starting at 0, for a
// programmed number of words. While the load runs, busy holds the
// processor off.
// Ports:
//   clk_i : rising-edge clock
//   rst_i : asynchronous, active-high reset
//   bus   : mem_stream_loader_if.slave, which carries the start/length
//           control, the byte valid/ready stream, the memory write port
//           and the status outputs
module mem_stream_loader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int DEPTH         = 4096
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mem_stream_loader_if.slave  bus
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_L = (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t                   state_q;
  logic [ADDRESS_WIDTH:0]   len_q;
  logic [CNT_W-1:0]         byteCnt_q;
  logic [DATA_WIDTH-1:0]    shift_q;
  logic                     memWEn_q;
  logic [ADDRESS_WIDTH-1:0] memAddr_q;
  logic [DATA_WIDTH-1:0]    memData_q;
  logic                     busy_q;
  logic                     done_q;
  logic [ADDRESS_WIDTH:0]   wordsWritten_q;

  logic [ADDRESS_WIDTH:0]   lenClamped;
  logic [DATA_WIDTH-1:0]    shifted;
  logic [ADDRESS_WIDTH:0]   wordsNext;

  // Requests longer than the memory are cut to DEPTH, so a load never wraps.
  // The shift moves earlier bytes toward the MSB. Written this way instead
  // of as a part-select, it also works when DATA_WIDTH is 8.
  always_comb begin
    lenClamped = (bus.load_len > DEPTH_L) ? DEPTH_L : bus.load_len;
    shifted    = (shift_q << 8) | DATA_WIDTH'(bus.byte_data);
    wordsNext  = wordsWritten_q + 1'b1;
  end

  // ready is the only output not taken from a register.
  assign bus.byte_ready    = (state_q == LOAD);
  assign bus.mem_wEn       = memWEn_q;
  assign bus.mem_addr      = memAddr_q;
  assign bus.mem_dataIn    = memData_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.words_written = wordsWritten_q;

  // Load FSM. A reset abandons any partial word at once. mem_wEn is only
  // ever high for the single WRITE cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      len_q          <= '0;
      byteCnt_q      <= '0;
      shift_q        <= '0;
      memWEn_q       <= 1'b0;
      memAddr_q      <= '0;
      memData_q      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      wordsWritten_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            len_q          <= lenClamped;
            wordsWritten_q <= '0;
            memAddr_q      <= '0;
            byteCnt_q      <= '0;
            shift_q        <= '0;
            if (lenClamped == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= LOAD;
              done_q  <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (bus.byte_valid) begin
            shift_q <= shifted;
            if (byteCnt_q == LAST_BYTE) begin
              byteCnt_q <= '0;
              memData_q <= shifted;
              memWEn_q  <= 1'b1;
              state_q   <= WRITE;
            end else begin
              byteCnt_q <= byteCnt_q + 1'b1;
            end
          end
        end

        WRITE: begin
          memWEn_q       <= 1'b0;
          memAddr_q      <= memAddr_q + 1'b1;
          wordsWritten_q <= wordsNext;
          if (wordsNext == len_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= LOAD;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_loader.sv
// tb_mem_stream_loader
// Scoreboard bench for mem_stream_loader. Expected {addr, data} writes are
// queued as their bytes are sent. They are popped and compared whenever the
// loader raises mem_wEn.
module tb_mem_stream_loader;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mem_stream_loader_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  mem_stream_loader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t  expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   consumed    = 0;
  int   writesSeen  = 0;
  logic prevWEn     = 1'b0;

  // One clock: note whether a byte is accepted at this edge, then sample
  // #1 later and check any write against the scoreboard.
  task automatic step();
    logic acc;
    wr_t  e;
    acc = (bus.byte_valid === 1'b1) && (bus.byte_ready === 1'b1);
    @(posedge clk);
    #1;
    if (acc) consumed++;
    if (bus.mem_wEn === 1'b1) begin
      writesSeen++;
      testsRun++;
      if (prevWEn) begin
        testsFailed++;
        $display("[TB] FAIL wEnWidth: mem_wEn high on consecutive cycles at addr %h, required 1-cycle pulse", bus.mem_addr);
      end else if (expQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL unexpectedWrite: got addr=%h data=%h, required no write", bus.mem_addr, bus.mem_dataIn);
      end else begin
        e = expQ.pop_front();
        if (bus.mem_addr !== e.addr || bus.mem_dataIn !== e.data) begin
          testsFailed++;
          $display("[TB] FAIL write: got addr=%h data=%h, required addr=%h data=%h", bus.mem_addr, bus.mem_dataIn, e.addr, e.data);
        end
      end
    end
    prevWEn = (bus.mem_wEn === 1'b1);
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap, output int waits);
    logic acc;
    bus.byte_valid = 1'b0;
    repeat (gap) step();
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    waits = 0;
    acc   = 1'b0;
    while (!acc && waits < 40) begin
      acc = (bus.byte_ready === 1'b1);
      step();
      waits++;
    end
    if (!acc) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL byteTimeout: byte %h not accepted within 40 cycles", b);
    end
  endtask

  task automatic sendWord(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int w;
    expQ.push_back('{addr: addr, data: data});
    for (int k = 0; k < 4; k++) sendByte(data[31-8*k -: 8], 0, w);
  endtask

  task automatic pulseStart(input logic [AW:0] len);
    bus.start    = 1'b1;
    bus.load_len = len;
    step();
    bus.start    = 1'b0;
  endtask

  task automatic waitDone(input int budget, input string name);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    testsRun++;
    if (bus.done !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL %s_doneTimeout: done=%b after %0d cycles, required 1", name, bus.done, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    testsRun++;
    if ({bus.byte_ready, bus.mem_wEn, bus.busy, bus.done} !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: ready/wEn/busy/done=%b, required 0000", {bus.byte_ready, bus.mem_wEn, bus.busy, bus.done});
    end
    testsRun++;
    if (bus.mem_addr !== '0 || bus.mem_dataIn !== '0 || bus.words_written !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_regs: addr=%h data=%h words=%0d, required 0/0/0", bus.mem_addr, bus.mem_dataIn, bus.words_written);
    end
    #9 rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int w0;
    w0 = writesSeen;
    pulseStart(2);
    testsRun++;
    if (bus.busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL basic_busy: busy=%b, required 1", bus.busy);
    end
    sendWord(12'h000, 32'hDEADBEEF);
    testsRun++;
    if (bus.mem_wEn !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL basic_latency0: mem_wEn=%b after byte 4, required 1", bus.mem_wEn);
    end
    sendWord(12'h001, 32'h01020304);
    testsRun++;
    if (bus.mem_wEn !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL basic_latency1: mem_wEn=%b after byte 8, required 1", bus.mem_wEn);
    end
    bus.byte_valid = 1'b0;
    waitDone(10, "basic");
    testsRun++;
    if (bus.busy !== 1'b0 || bus.words_written !== 13'd2 || writesSeen - w0 != 2 || expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL basic_final: busy=%b words=%0d writes=%0d pending=%0d, required 0/2/2/0", bus.busy, bus.words_written, writesSeen - w0, expQ.size());
    end
  endtask

  task automatic test_zero_len();
    int c0, w0;
    c0 = consumed;
    w0 = writesSeen;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h55;
    pulseStart(0);
    testsRun++;
    if (bus.done !== 1'b1 || bus.byte_ready !== 1'b0 || bus.busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL zero_state: done/ready/busy=%b%b%b, required 100", bus.done, bus.byte_ready, bus.busy);
    end
    repeat (5) step();
    bus.byte_valid = 1'b0;
    testsRun++;
    if (consumed != c0 || writesSeen != w0 || bus.words_written !== '0) begin
      testsFailed++;
      $display("[TB] FAIL zero_idle: consumed=%0d writes=%0d words=%0d, required 0/0/0", consumed - c0, writesSeen - w0, bus.words_written);
    end
  endtask

  task automatic test_gaps();
    int c0, waits, gap;
    logic [31:0] d;
    c0 = consumed;
    bus.byte_valid = 1'b0;
    pulseStart(3);
    for (int w = 0; w < 3; w++) begin
      d = $urandom;
      expQ.push_back('{addr: AW'(w), data: d});
      for (int k = 0; k < 4; k++) begin
        gap = (k == 0) ? 0 : int'($urandom_range(0, 5));
        sendByte(d[31-8*k -: 8], gap, waits);
        if (k == 0 && w > 0) begin
          testsRun++;
          if (waits != 2) begin
            testsFailed++;
            $display("[TB] FAIL gaps_writeHold%0d: byte held over WRITE took %0d cycles, required 2", w, waits);
          end
        end
      end
    end
    bus.byte_valid = 1'b0;
    waitDone(10, "gaps");
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h99;
    repeat (4) step();
    bus.byte_valid = 1'b0;
    testsRun++;
    if (consumed - c0 != 12 || bus.words_written !== 13'd3 || expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL gaps_count: consumed=%0d words=%0d pending=%0d, required 12/3/0", consumed - c0, bus.words_written, expQ.size());
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] words [4];
    int waits;
    words[0] = 32'h10203040; words[1] = 32'h50607080;
    words[2] = 32'h90A0B0C0; words[3] = 32'hD0E0F001;
    bus.byte_valid = 1'b0;
    pulseStart(4);
    for (int w = 0; w < 4; w++) expQ.push_back('{addr: AW'(w), data: words[w]});
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        bus.byte_valid = 1'b0;
        pulseStart(1);
      end
      sendByte(words[i/4][31-8*(i%4) -: 8], 0, waits);
    end
    bus.byte_valid = 1'b0;
    waitDone(10, "startIgn");
    testsRun++;
    if (bus.words_written !== 13'd4 || bus.mem_addr !== 12'h004 || expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL startIgn_final: words=%0d addr=%h pending=%0d, required 4/004/0", bus.words_written, bus.mem_addr, expQ.size());
    end
  endtask

  task automatic test_async_reset();
    int waits, w0;
    bus.byte_valid = 1'b0;
    pulseStart(2);
    sendWord(12'h000, 32'h11223344);
    sendByte(8'h55, 0, waits);
    sendByte(8'h66, 0, waits);
    bus.byte_valid = 1'b0;
    w0 = writesSeen;
    #2 rst = 1'b1;
    #1;
    testsRun++;
    if (bus.mem_wEn !== 1'b0 || bus.busy !== 1'b0 || bus.byte_ready !== 1'b0 || bus.done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL async_drop: wEn/busy/ready/done=%b%b%b%b, required 0000", bus.mem_wEn, bus.busy, bus.byte_ready, bus.done);
    end
    #3 rst = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h77;
    repeat (4) step();
    bus.byte_valid = 1'b0;
    testsRun++;
    if (writesSeen != w0 || bus.words_written !== '0) begin
      testsFailed++;
      $display("[TB] FAIL async_noWrite: writes=%0d words=%0d after reset, required 0/0", writesSeen - w0, bus.words_written);
    end
    pulseStart(1);
    sendWord(12'h000, 32'hAABBCCDD);
    bus.byte_valid = 1'b0;
    waitDone(10, "async");
    testsRun++;
    if (bus.words_written !== 13'd1 || expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL async_reload: words=%0d pending=%0d, required 1/0", bus.words_written, expQ.size());
    end
  endtask

  task automatic test_clamp();
    int w0;
    logic [31:0] d;
    w0 = writesSeen;
    bus.byte_valid = 1'b0;
    pulseStart(13'd4101);
    for (int i = 0; i < DEPTH; i++) begin
      d = {i[7:0], i[15:8], 8'hA5, ~i[7:0]};
      sendWord(AW'(i), d);
    end
    bus.byte_valid = 1'b0;
    waitDone(10, "clamp");
    testsRun++;
    if (bus.words_written !== 13'd4096 || bus.mem_addr !== 12'h000 || bus.busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL clamp_final: words=%0d addr=%h busy=%b, required 4096/000/0", bus.words_written, bus.mem_addr, bus.busy);
    end
    testsRun++;
    if (writesSeen - w0 != DEPTH || expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL clamp_count: writes=%0d pending=%0d, required 4096/0", writesSeen - w0, expQ.size());
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.load_len   = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    test_reset();
    test_basic();
    test_zero_len();
    test_gaps();
    test_start_ignored();
    test_async_reset();
    test_clamp();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation still running at 2ms, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_stream_loader.md
Name: mem_stream_loader

Overview:
- Writer-side companion to the synchronous instruction/data memory.
- Accepts a byte stream, for example from a UART receiver or debug port, over a valid/ready handshake.
- Packs the bytes into DATA_WIDTH-bit words, MSB first, and drives the memory's write-enable/address/data port for a programmed number of words starting at address 0.
- Sits between the boot/debug byte source and the memory, and holds the processor off via busy until loading completes.

Parameters:
- DATA_WIDTH, 32: memory word width; must be a multiple of 8; BYTES = DATA_WIDTH/8.
- ADDRESS_WIDTH, 12: memory address width.
- DEPTH, 4096: number of memory words; upper limit for load length.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load; sampled only in IDLE or DONE.
- load_len  input  ADDRESS_WIDTH+1  number of words to write; sampled on the accepted start.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  incoming byte.
- byte_ready  output  1  loader can accept a byte this cycle.
- mem_wEn  output  1  write enable to the memory.
- mem_addr  output  ADDRESS_WIDTH  memory write address.
- mem_dataIn  output  DATA_WIDTH  memory write data.
- busy  output  1  high while a load is in progress (LOAD or WRITE).
- done  output  1  high in DONE; held until the next accepted start or reset.
- words_written  output  ADDRESS_WIDTH+1  count of words committed in the current or last load.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State = IDLE.
  - byte_ready, mem_wEn, busy and done = 0.
  - mem_addr, mem_dataIn, words_written, byte counter and shift register = 0.
  - A reset mid-load abandons the partial word; no further writes occur and mem_wEn drops without waiting for a clock edge.
- States: IDLE, LOAD, WRITE, DONE. All outputs are registered except byte_ready, which is decoded from state (1 only in LOAD).
- IDLE/DONE, start=1:
  - len_q = min(load_len, DEPTH).
  - words_written = 0, mem_addr = 0, byte counter = 0, done = 0.
  - If len_q == 0, go directly to DONE (done=1 on the next cycle). Otherwise go to LOAD and set busy=1.
- start while busy is ignored.
- LOAD:
  - A byte is accepted on a cycle with byte_valid && byte_ready.
  - On acceptance: shift register = {shift[DATA_WIDTH-9:0], byte_data}; byte counter increments.
  - When the accepted byte is byte number BYTES, the next state is WRITE, mem_dataIn = the assembled word (the first byte lands in bits [DATA_WIDTH-1:DATA_WIDTH-8]), and the byte counter clears.
  - byte_valid with no byte pending is a no-op. Gaps between bytes of any length are allowed.
- WRITE (exactly one cycle):
  - mem_wEn=1 with mem_addr and mem_dataIn stable; byte_ready=0, so bytes offered this cycle are not consumed and the source must hold them.
  - On leaving WRITE: words_written increments, mem_wEn returns to 0 and mem_addr increments.
  - If words_written+1 == len_q, go to DONE (busy=0, done=1, mem_addr holds last+1 truncated to ADDRESS_WIDTH). Otherwise go back to LOAD.
- Throughput: a word of BYTES back-to-back bytes produces mem_wEn on the cycle after the last byte is accepted, giving BYTES+1 cycles per word.
- Wrap-around: addresses never exceed len_q-1 ≤ DEPTH-1, so there is no wrap within a load. load_len > DEPTH is clamped to DEPTH.
- DONE: byte_ready=0; stray bytes are ignored and not consumed. words_written holds the final count.

Test Plan:
- Reset, then start with load_len=2 and bytes DE AD BE EF 01 02 03 04 back-to-back:
  - mem_wEn pulses at addr 0 with data 0xDEADBEEF, then at addr 1 with data 0x01020304.
  - done=1, busy=0, words_written=2.
  - Each mem_wEn is exactly 1 cycle wide and the cycle after byte 4 / byte 8.
- Start with load_len=0:
  - No mem_wEn, byte_ready stays 0, done=1 on the following cycle, words_written=0.
- Bytes with random 0–5 cycle gaps plus byte_valid held high during WRITE, load_len=3:
  - Exactly 12 bytes consumed (counted where valid&&ready).
  - The byte offered during WRITE is consumed on the next LOAD cycle.
  - Writes go to addresses 0, 1, 2 with the correct packed data.
- Start pulse mid-load (after 5 bytes of load_len=4):
  - Ignored; load finishes with 4 writes at addrs 0–3.
- Assert reset asynchronously after 2 bytes of word 1:
  - mem_wEn, busy and byte_ready drop immediately.
  - No write occurs for the partial word.
  - A new start with load_len=1 and bytes AA BB CC DD writes 0xAABBCCDD to addr 0.
- load_len=DEPTH+5 (4101):
  - Clamped to 4096 writes; the last write is at addr 0xFFF, then done=1 and words_written=4096.
